// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares the A/B ports of a dual-port RAM among NREQ
// requesters. Each cycle it grants up to two requests round-robin (first to
// port A, second to port B), skips same-address hazards, and returns read
// data to the originating requester two cycles after the grant.
// Optional: define DPRAM_ARB_COLL_CNT_EN to add a saturating 16-bit
// conflict-cycle counter output coll_cnt.
module dpram_port_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [NREQ*WIDTH-1:0] rdata,
  output logic                  w_en_a,
  output logic                  w_en_b,
  output logic [AW-1:0]         addr_a,
  output logic [AW-1:0]         addr_b,
  output logic [WIDTH-1:0]      data_in_a,
  output logic [WIDTH-1:0]      data_in_b,
  input  logic [WIDTH-1:0]      data_out_a,
  input  logic [WIDTH-1:0]      data_out_b
`ifdef DPRAM_ARB_COLL_CNT_EN
  ,
  output logic [15:0]           coll_cnt
`endif
);

  logic [PW-1:0] ptr;
  logic          found_a, found_b, skipped;
  logic [PW-1:0] idx_a, idx_b, cand;

  // Read tags: stage 1 travels with the port registers, stage 2 with data_out
  logic          t1a_v, t1b_v, t2a_v, t2b_v;
  logic [PW-1:0] t1a_i, t1b_i, t2a_i, t2b_i;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin scan from ptr: first request -> A, next non-conflicting -> B
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    skipped = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(ptr) + k) % NREQ);
      if (req[cand]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = cand;
        end else if (!found_b) begin
          // Read/read to the same word is harmless; anything with a write is not
          if ((addr[cand*AW +: AW] == addr[idx_a*AW +: AW]) && (we[cand] || we[idx_a]))
            skipped = 1'b1;
          else begin
            found_b = 1'b1;
            idx_b   = cand;
          end
        end
      end
    end
  end

  // Grant vector, forced low while reset is asserted
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (found_a) gnt[idx_a] = 1'b1;
      if (found_b) gnt[idx_b] = 1'b1;
    end
  end

  // Pointer, registered RAM port signals and read-tag pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      w_en_a    <= 1'b0;
      w_en_b    <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      data_in_a <= '0;
      data_in_b <= '0;
      t1a_v     <= 1'b0;
      t1b_v     <= 1'b0;
      t2a_v     <= 1'b0;
      t2b_v     <= 1'b0;
      t1a_i     <= '0;
      t1b_i     <= '0;
      t2a_i     <= '0;
      t2b_i     <= '0;
    end else begin
      if (found_b)      ptr <= next_idx(idx_b);
      else if (found_a) ptr <= next_idx(idx_a);

      w_en_a <= found_a & we[idx_a];
      w_en_b <= found_b & we[idx_b];
      if (found_a) begin
        addr_a    <= addr[idx_a*AW +: AW];
        data_in_a <= wdata[idx_a*WIDTH +: WIDTH];
      end
      if (found_b) begin
        addr_b    <= addr[idx_b*AW +: AW];
        data_in_b <= wdata[idx_b*WIDTH +: WIDTH];
      end

      t1a_v <= found_a & ~we[idx_a];
      t1b_v <= found_b & ~we[idx_b];
      t1a_i <= idx_a;
      t1b_i <= idx_b;
      t2a_v <= t1a_v;
      t2b_v <= t1b_v;
      t2a_i <= t1a_i;
      t2b_i <= t1b_i;
    end
  end

  // Route RAM read data back to the requester that owns each port's tag
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (t2a_v) begin
      rvalid[t2a_i]                = 1'b1;
      rdata[t2a_i*WIDTH +: WIDTH]  = data_out_a;
    end
    if (t2b_v) begin
      rvalid[t2b_i]                = 1'b1;
      rdata[t2b_i*WIDTH +: WIDTH]  = data_out_b;
    end
  end

`ifdef DPRAM_ARB_COLL_CNT_EN
  // Saturating count of cycles in which a request was held off by a conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coll_cnt <= '0;
    else if (skipped && (coll_cnt != '1))
      coll_cnt <= coll_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Testbench for dpram_port_arbiter with a behavioural dual-port RAM.
// Read results are checked by a scoreboard monitor; grants and port
// signals are checked inline by the directed stimulus.
module tb_dpram_port_arbiter;

  logic        clk, rst;
  logic [3:0]  req, we, gnt, rvalid;
  logic [11:0] addr;
  logic [31:0] wdata, rdata;
  logic        w_en_a, w_en_b;
  logic [2:0]  addr_a, addr_b;
  logic [7:0]  data_in_a, data_in_b, data_out_a, data_out_b;
`ifdef DPRAM_ARB_COLL_CNT_EN
  logic [15:0] coll_cnt;
`endif

  dpram_port_arbiter #(.NREQ(4), .DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .w_en_a(w_en_a), .w_en_b(w_en_b), .addr_a(addr_a), .addr_b(addr_b),
    .data_in_a(data_in_a), .data_in_b(data_in_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b)
`ifdef DPRAM_ARB_COLL_CNT_EN
    , .coll_cnt(coll_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, registered read
  logic [7:0] mem [8];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h30 + 8'(i);
    end else begin
      if (w_en_a) mem[addr_a] <= data_in_a;
      if (w_en_b) mem[addr_b] <= data_in_b;
    end
    data_out_a <= mem[addr_a];
    data_out_b <= mem[addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  // Monitor: every rvalid must match an outstanding expected read
  int hit;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (rvalid[i]) begin
          hit = -1;
          for (int k = 0; k < sb.size(); k++)
            if (hit < 0 && sb[k].idx == i) hit = k;
          vectors++;
          if (hit < 0) begin
            miscompares++;
            $display("FAIL rvalid_unexpected req%0d: got rvalid=1 data=%h cyc=%0d, required no rvalid",
                     i, rdata[i*8 +: 8], cyc);
          end else begin
            if (rdata[i*8 +: 8] !== sb[hit].data || cyc != sb[hit].due) begin
              miscompares++;
              $display("FAIL rdata_req%0d: got data=%h cyc=%0d, required data=%h cyc=%0d",
                       i, rdata[i*8 +: 8], cyc, sb[hit].data, sb[hit].due);
            end
            sb.delete(hit);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req = '0;
    we  = '0;
  endtask

  task automatic set(input int i, input logic w, input logic [2:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*3 +: 3]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic push(input int i, input logic [7:0] d);
    sb.push_back(exp_t'{idx: i, data: d, due: cyc + 2});
  endtask

  logic [3:0] exp_g [4];
  logic [7:0] rd_exp [4];

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    clr(); addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_w_en_a", w_en_a, 0);
    chk("rst_w_en_b", w_en_b, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_data_in_a", data_in_a, 0);
    chk("rst_data_in_b", data_in_b, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    req = 4'b1111; #1;
    chk("rst_gnt_req", gnt, 0);
    clr(); mem_init = 1'b0; rst = 1'b0;
    tick();

    // Write then read back, ptr=0
    set(0, 1'b1, 3'd3, 8'hA5); #1;
    chk("wr_gnt", gnt, 4'b0001);
    tick(); clr(); #1;
    chk("wr_w_en_a", w_en_a, 1);
    chk("wr_addr_a", addr_a, 3);
    chk("wr_data_in_a", data_in_a, 8'hA5);
    chk("wr_w_en_b", w_en_b, 0);
    tick(); set(0, 1'b0, 3'd3, 8'h00); #1;
    chk("rd_gnt", gnt, 4'b0001); push(0, 8'hA5);
    tick(); clr(); #1;
    chk("rd_w_en_a", w_en_a, 0);
    chk("rd_addr_a", addr_a, 3);
    repeat (3) tick();

    // Reset during an in-flight read, ptr=1
    set(2, 1'b0, 3'd1, 8'h00); #1;
    chk("mid_gnt", gnt, 4'b0100);
    tick(); clr(); #1;
    chk("mid_addr_a_pre", addr_a, 1);
    rst = 1'b1; #1;
    chk("mid_addr_a_rst", addr_a, 0);
    chk("mid_rvalid_rst", rvalid, 0);
    tick(); rst = 1'b0;
    repeat (3) tick();

    // Two reads in one cycle, ptr=0
    set(1, 1'b0, 3'd2, 8'h00); set(2, 1'b0, 3'd5, 8'h00); #1;
    chk("dual_gnt", gnt, 4'b0110); push(1, 8'h32); push(2, 8'h35);
    tick(); clr(); #1;
    chk("dual_addr_a", addr_a, 2);
    chk("dual_addr_b", addr_b, 5);
    chk("dual_w_en", {w_en_a, w_en_b}, 0);
    repeat (3) tick();

    // Single requester moves ptr from 3 to 0
    set(3, 1'b0, 3'd6, 8'h00); #1;
    chk("steer1_gnt", gnt, 4'b1000); push(3, 8'h36);
    tick(); clr(); repeat (3) tick();
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_pre", coll_cnt, 0);
`endif

    // Write/read conflict on address 4, ptr=0
    set(0, 1'b1, 3'd4, 8'h5C); set(1, 1'b0, 3'd4, 8'h00); #1;
    chk("conf_gnt0", gnt, 4'b0001);
    tick(); req[0] = 1'b0; we[0] = 1'b0; #1;
    chk("conf_gnt1", gnt, 4'b0010); push(1, 8'h5C);
    chk("conf_w_en_a", w_en_a, 1);
    chk("conf_addr_a", addr_a, 4);
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_conf", coll_cnt, 1);
`endif
    tick(); clr(); #1;
    chk("conf_rd_w_en_a", w_en_a, 0);
    chk("conf_rd_addr_a", addr_a, 4);
    repeat (3) tick();

    // Read/read on the same address is not a conflict, ptr=2
    set(0, 1'b0, 3'd7, 8'h00); set(3, 1'b0, 3'd7, 8'h00); #1;
    chk("rr_gnt", gnt, 4'b1001); push(3, 8'h37); push(0, 8'h37);
    tick(); clr(); #1;
    chk("rr_addr_a", addr_a, 7);
    chk("rr_addr_b", addr_b, 7);
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_rr", coll_cnt, 1);
`endif
    repeat (3) tick();

    // ptr=1: lone req3 returns ptr to 0
    set(3, 1'b0, 3'd0, 8'h00); #1;
    chk("steer2_gnt", gnt, 4'b1000); push(3, 8'h30);
    tick(); clr(); repeat (3) tick();

    // All four read distinct addresses for four cycles
    exp_g  = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    rd_exp = '{8'h30, 8'h31, 8'h32, 8'hA5};
    for (int i = 0; i < 4; i++) set(i, 1'b0, 3'(i), 8'h00);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("all_rd_gnt%0d", c), gnt, exp_g[c]);
      for (int i = 0; i < 4; i++) if (exp_g[c][i]) push(i, rd_exp[i]);
      tick();
    end
    clr();
    repeat (3) tick();
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_all_rd", coll_cnt, 1);
`endif

    // All four write address 6: one grant per cycle, rotating
    for (int i = 0; i < 4; i++) set(i, 1'b1, 3'd6, 8'h60 + 8'(i));
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("all_wr_gnt%0d", c), gnt, 4'b0001 << c);
      tick();
    end
    clr(); #1;
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_all_wr", coll_cnt, 5);
`endif
    tick();
    set(2, 1'b0, 3'd6, 8'h00); #1;
    chk("last_wr_gnt", gnt, 4'b0100); push(2, 8'h63);
    tick(); clr();
    repeat (6) tick();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares the two ports (A, B) of the dual-port RAM between NREQ requesters.
- Per cycle, grants up to two requests round-robin and maps the first grant to port A and the second to port B.
- Suppresses same-address hazards within a cycle and routes read data back to the originating requester.
- Sits between bus-side masters and the dual-port RAM instance; it is the only driver of the RAM port signals.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 8, RAM words; address width AW = $clog2(DEPTH).
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held until granted.
- we  input  NREQ  1 = write, 0 = read; valid while req is high.
- addr  input  NREQ*AW  flattened per-requester address (slice i = requester i).
- wdata  input  NREQ*WIDTH  flattened write data.
- gnt  output  NREQ  transfer accepted this cycle (req[i] & gnt[i]).
- rvalid  output  NREQ  read data valid for requester i.
- rdata  output  NREQ*WIDTH  flattened read data; slice i is meaningful only while rvalid[i] is high.
- w_en_a, w_en_b  output  1 each  RAM write enables.
- addr_a, addr_b  output  AW each  RAM addresses.
- data_in_a, data_in_b  output  WIDTH each  RAM write data.
- data_out_a, data_out_b  input  WIDTH each  RAM read data.

Behaviour:
- RAM contract: synchronous write; registered read where data_out reflects the addr sampled at the previous edge.

Reset (async, rst=1):
- gnt, rvalid, rdata, w_en_a/b, addr_a/b, data_in_a/b all 0.
- Round-robin pointer ptr = 0.
- Both read-tag pipelines cleared.
- Reset mid-operation drops in-flight reads: no rvalid is emitted for them after reset.

Arbitration (combinational within cycle t; gnt is combinational from req/we/addr and ptr):
- Scan indices ptr, ptr+1, ... modulo NREQ.
- First requester with req=1 becomes grant A.
- Continue scanning: the next requester with req=1 that does NOT conflict with grant A becomes grant B.
- Conflict: same address AND at least one of the pair is a write. Two reads to the same address do not conflict.
- Conflicting requesters are skipped (not granted) and retry next cycle.
- ptr update at edge: ptr <= (index of last grant issued this cycle + 1) mod NREQ; unchanged when no grant.
- At most two gnt bits high per cycle; never the same bit twice.

Pipeline:
- Cycle t+1: registered port signals. Port A is driven from grant A, port B from grant B.
  - Unused port: w_en=0, addr and data_in hold their previous values.
  - w_en_x = we of the granted requester; data_in_x = its wdata slice.
- Read tag per port (valid + requester index) is registered alongside and delayed one more stage.
- Cycle t+2: for a granted read, rvalid[i]=1 for exactly one cycle and rdata slice i = data_out of the port used.
- Writes produce no rvalid.
- Read latency from grant: 2 cycles.
- Throughput: 2 transfers/cycle when conflict-free.

Boundary conditions:
- Single requester active: always port A, port B idle.
- All requesters write the same address: one granted per cycle, fair rotation.
- A requester granted at t may re-request at t+1 and is eligible again. Rotation guarantees every requester is served within NREQ cycles, even with all requesters contending.
- A read and a write to the same address in different cycles: the read returns the value as ordered by RAM edges. A write granted at t is visible to a read granted at t+1.

Optional Feature:
- Macro: DPRAM_ARB_COLL_CNT_EN.
- When defined: adds output port coll_cnt [15:0].
  - Increments by 1 each cycle in which at least one requester with req=1 was skipped due to an address conflict.
  - Saturates at 16'hFFFF; reset to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset → ptr=0, all outputs 0. Assert rst during an in-flight read at t+1 → no rvalid afterwards.
- Req0 write addr 3 data 8'hA5 at t; req0 read addr 3 at t+2 → w_en_a=1, addr_a=3 at t+1; rvalid[0]=1, rdata0=8'hA5 at t+4.
- Req1 read addr 2 and req2 read addr 5 in the same cycle, ptr=0 → gnt=4'b0110; port A=req1, port B=req2; both rvalid asserted 2 cycles later with the correct data.
- Req0 write addr 4 and req1 read addr 4 in the same cycle, ptr=0 → gnt=4'b0001; req1 granted next cycle, reads the new value. coll_cnt=1 when the macro is enabled.
- All 4 requesters hold read requests to distinct addresses for 4 cycles → grants 0,1 then 2,3 then 0,1. Each requester receives rvalid within NREQ cycles.
- Req0 and req3 both read addr 7, ptr=2 → req3 on port A, req0 on port B in the same cycle (no conflict); coll_cnt unchanged.
